ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter: sends one command byte to the attached keyboard or mouse, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- It is the opposite direction of the existing PS/2 scan-code receive path. Both share PS2_CLK and PS2_DAT.
- The block drives the bus open-drain through low-enables. The top level ties each line to 1'b0 when its low-enable is 1, and to 1'bz otherwise.
- busy is exported so the receive path can ignore bus activity during a host transmission.

---
 rtl/ps2_host_tx_if.sv | 38 +++
 rtl/ps2_host_tx.sv | 250 +++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_if -- bundle of the PS/2 host-transmit request and bus signals.
//
//   send         request pulse from the command source
//   cmd_byte     command byte presented with send
//   ps2_clk_in   sampled level of the shared PS2_CLK line
//   ps2_dat_in   sampled level of the shared PS2_DAT line
//   ps2_clk_low  1 = transmitter pulls PS2_CLK low
//   ps2_dat_low  1 = transmitter pulls PS2_DAT low
//   busy         transmission in progress (receive path should ignore bus)
//   done         one-cycle pulse: byte sent and acked by the device
//   error        one-cycle pulse: transfer aborted
//   err_code     abort reason, valid with error, held until next accept
//
// master: the command source / pad side.  slave: the transmitter.
// ---------------------------------------------------------------------------
interface ps2_host_tx_if;
   logic       send;
   logic [7:0] cmd_byte;
   logic       ps2_clk_in;
   logic       ps2_dat_in;
   logic       ps2_clk_low;
   logic       ps2_dat_low;
   logic       busy;
   logic       done;
   logic       error;
   logic [1:0] err_code;

   modport master (
      output send, cmd_byte, ps2_clk_in, ps2_dat_in,
      input  ps2_clk_low, ps2_dat_low, busy, done, error, err_code
   );

   modport slave (
      input  send, cmd_byte, ps2_clk_in, ps2_dat_in,
      output ps2_clk_low, ps2_dat_low, busy, done, error, err_code
   );
endinterface

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx -- PS/2 host-to-device command transmitter.
//
// Sends one byte (start 0, D0..D7 LSB first, odd parity, stop 1) to the
// attached keyboard/mouse and checks the device ack bit.  The bus is driven
// open-drain through low-enables; the top level turns each enable into
// 1'b0 / 1'bz on the pin.
//
// Ports:
//   CLOCK_50  system clock (50 MHz)
//   Resetn    asynchronous active-low reset
//   bus       ps2_host_tx_if.slave: send/cmd_byte request, sampled line
//             levels in, low-enables out, busy/done/error/err_code status
//
// err_code: 01 start timeout, 10 transfer timeout, 11 NACK.
// ---------------------------------------------------------------------------
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,    // CLK held low before the request
   parameter int SETUP_CYCLES   = 50,      // CLK and DAT both low before release
   parameter int START_TIMEOUT  = 750000,  // release -> first device fall
   parameter int XFER_TIMEOUT   = 100000,  // release -> ack edge / idle
   parameter int CNT_W          = 20       // must hold the largest value above
) (
   input  logic          CLOCK_50,
   input  logic          Resetn,
   ps2_host_tx_if.slave  bus
);

   localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT - 1);

   localparam logic [1:0] ERR_START = 2'b01;
   localparam logic [1:0] ERR_XFER  = 2'b10;
   localparam logic [1:0] ERR_NACK  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_SETUP,
      S_WAIT_FIRST,
      S_SHIFT,
      S_WAIT_IDLE
   } state_t;

   state_t           state_q,    state_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [3:0]       bidx_q,     bidx_d;
   logic [8:0]       frame_q,    frame_d;     // {parity, data}, shifts out LSB first
   logic             clk_low_q,  clk_low_d;
   logic             dat_low_q,  dat_low_d;
   logic             busy_q,     busy_d;
   logic             done_q,     done_d;
   logic             error_q,    error_d;
   logic [1:0]       err_code_q, err_code_d;

   // ---------------------------------------------------------------------
   // Line synchronizers and falling-edge detect on PS2_CLK
   // ---------------------------------------------------------------------
   logic [1:0] clk_sync;
   logic [1:0] dat_sync;
   logic       clk_prev;
   logic       sync_clk;
   logic       sync_dat;
   logic       fall;

   assign sync_clk = clk_sync[1];
   assign sync_dat = dat_sync[1];
   assign fall     = clk_prev & ~sync_clk;

   // NOTE: the synchronizer flops reset to the idle-high bus level so that
   // leaving reset never fabricates a falling edge on PS2_CLK.
   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         clk_prev <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[0], bus.ps2_clk_in};
         dat_sync <= {dat_sync[0], bus.ps2_dat_in};
         clk_prev <= clk_sync[1];
      end
   end

   // ---------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------
   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values computed by the combinational block.
   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bidx_q     <= '0;
         frame_q    <= '0;
         clk_low_q  <= 1'b0;
         dat_low_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         err_code_q <= 2'b00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bidx_q     <= bidx_d;
         frame_q    <= frame_d;
         clk_low_q  <= clk_low_d;
         dat_low_q  <= dat_low_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         err_code_q <= err_code_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state / next-output logic
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case statement, so no
      // path leaves a value unassigned and no latch is inferred.
      state_d    = state_q;
      cnt_d      = cnt_q;
      bidx_d     = bidx_q;
      frame_d    = frame_q;
      clk_low_d  = clk_low_q;
      dat_low_d  = dat_low_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      error_d    = 1'b0;
      err_code_d = err_code_q;

      unique case (state_q)
         S_IDLE: begin
            clk_low_d = 1'b0;
            dat_low_d = 1'b0;
            if (bus.send) begin
               frame_d    = {~^bus.cmd_byte, bus.cmd_byte};
               busy_d     = 1'b1;
               err_code_d = 2'b00;
               cnt_d      = '0;
               clk_low_d  = 1'b1;
               state_d    = S_INHIBIT;
            end
         end

         S_INHIBIT: begin
            if (cnt_q == INH_LAST) begin
               cnt_d     = '0;
               dat_low_d = 1'b1;               // start bit
               state_d   = S_SETUP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               cnt_d     = '0;
               bidx_d    = '0;
               clk_low_d = 1'b0;               // hand the clock to the device
               state_d   = S_WAIT_FIRST;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_WAIT_FIRST: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q >= START_LAST) begin
               error_d    = 1'b1;
               err_code_d = ERR_START;
               busy_d     = 1'b0;
               clk_low_d  = 1'b0;
               dat_low_d  = 1'b0;
               state_d    = S_IDLE;
            end else if (fall) begin
               dat_low_d = ~frame_q[0];
               frame_d   = {1'b0, frame_q[8:1]};
               bidx_d    = 4'd1;
               state_d   = S_SHIFT;
            end
         end

         S_SHIFT: begin
            cnt_d = cnt_q + 1'b1;
            // The running transfer timeout wins over a coincident fall.
            if (cnt_q >= XFER_LAST) begin
               error_d    = 1'b1;
               err_code_d = ERR_XFER;
               busy_d     = 1'b0;
               clk_low_d  = 1'b0;
               dat_low_d  = 1'b0;
               state_d    = S_IDLE;
            end else if (fall) begin
               if (bidx_q <= 4'd8) begin
                  // D1..D7, then parity
                  dat_low_d = ~frame_q[0];
                  frame_d   = {1'b0, frame_q[8:1]};
                  bidx_d    = bidx_q + 1'b1;
               end else if (bidx_q == 4'd9) begin
                  dat_low_d = 1'b0;            // stop bit, also frees DAT for ack
                  bidx_d    = 4'd10;
               end else if (!sync_dat) begin
                  state_d   = S_WAIT_IDLE;     // device acked
               end else begin
                  error_d    = 1'b1;
                  err_code_d = ERR_NACK;
                  busy_d     = 1'b0;
                  clk_low_d  = 1'b0;
                  dat_low_d  = 1'b0;
                  state_d    = S_IDLE;
               end
            end
         end

         S_WAIT_IDLE: begin
            cnt_d     = cnt_q + 1'b1;
            clk_low_d = 1'b0;
            dat_low_d = 1'b0;
            if (cnt_q >= XFER_LAST) begin
               error_d    = 1'b1;
               err_code_d = ERR_XFER;
               busy_d     = 1'b0;
               state_d    = S_IDLE;
            end else if (sync_clk && sync_dat) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end

         default: begin
            busy_d    = 1'b0;
            clk_low_d = 1'b0;
            dat_low_d = 1'b0;
            state_d   = S_IDLE;
         end
      endcase
   end

   assign bus.ps2_clk_low = clk_low_q;
   assign bus.ps2_dat_low = dat_low_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.error       = error_q;
   assign bus.err_code    = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx -- directed bench for ps2_host_tx with a simple PS/2 device
// model clocking at a 40-cycle period (20 high / 20 low).  Data is read by
// the device model at each rising edge; the ack is driven before edge 11.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int INH   = 20;
   localparam int SETUP = 4;
   localparam int START = 200;
   localparam int XFER  = 600;

   logic CLOCK_50 = 1'b0;
   logic Resetn   = 1'b0;

   ps2_host_tx_if bus ();

   logic dev_clk_low = 1'b0;
   logic dev_dat_low = 1'b0;
   logic line_clk;
   logic line_dat;

   assign line_clk       = !(bus.ps2_clk_low || dev_clk_low);
   assign line_dat       = !(bus.ps2_dat_low || dev_dat_low);
   assign bus.ps2_clk_in = line_clk;
   assign bus.ps2_dat_in = line_dat;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .SETUP_CYCLES   (SETUP),
      .START_TIMEOUT  (START),
      .XFER_TIMEOUT   (XFER),
      .CNT_W          (20)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .Resetn   (Resetn),
      .bus      (bus)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int compared   = 0;
   int mismatched = 0;

   // Pulse monitor: runs on the falling edge, tests read at negedge + 1.
   int         ncyc      = 0;
   int         done_cnt  = 0;
   int         error_cnt = 0;
   int         err_ncyc  = 0;
   logic       done_busy = 1'b0;
   logic [1:0] err_code_seen = 2'b00;
   logic       err_clk_low = 1'b0;
   logic       err_dat_low = 1'b0;

   always @(negedge CLOCK_50) begin
      ncyc++;
      if (bus.done === 1'b1) begin
         done_cnt++;
         done_busy = bus.busy;
      end
      if (bus.error === 1'b1) begin
         error_cnt++;
         err_ncyc      = ncyc;
         err_code_seen = bus.err_code;
         err_clk_low   = bus.ps2_clk_low;
         err_dat_low   = bus.ps2_dat_low;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, need completion", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLOCK_50);
         #1;
      end
   endtask

   task automatic apply_reset();
      Resetn      = 1'b0;
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      bus.send    = 1'b0;
      tick(3);
      Resetn = 1'b1;
      tick(2);
   endtask

   task automatic send_cmd(input logic [7:0] cmd);
      tick(1);
      bus.send     = 1'b1;
      bus.cmd_byte = cmd;
      tick(1);
      bus.send     = 1'b0;
   endtask

   // Wait for CLK released with the start bit on DAT; returns the cycle index.
   task automatic wait_release(input string tag, output int rel);
      int waited = 0;
      rel = 0;
      while (!(bus.ps2_clk_low === 1'b0 && bus.ps2_dat_low === 1'b1) && waited < 200) begin
         tick(1);
         waited++;
      end
      rel = ncyc;
      if (waited >= 200) begin
         compared++;
         mismatched++;
         $display("FAIL %s_release: clk_low=%b dat_low=%b, need 0/1 within 200 cycles",
                  tag, bus.ps2_clk_low, bus.ps2_dat_low);
      end
   endtask

   // Device model: n_edges clock pulses; bits[0] = start, [1..8] data,
   // [9] parity, [10] stop.  Edge 11 is the ack edge.
   task automatic run_bfm(input int n_edges, input bit ack_high, output logic [10:0] bits);
      bits    = '0;
      bits[0] = line_dat;
      for (int i = 1; i <= n_edges; i++) begin
         if (i == 11) dev_dat_low = !ack_high;
         tick(20);
         dev_clk_low = 1'b1;
         tick(20);
         if (i <= 10) bits[i] = line_dat;
         dev_clk_low = 1'b0;
         if (i == 11) dev_dat_low = 1'b0;
      end
   endtask

   task automatic wait_count(input string tag, input int base_done, input int base_err,
                             input int budget);
      int waited = 0;
      while (done_cnt == base_done && error_cnt == base_err && waited < budget) begin
         tick(1);
         waited++;
      end
      if (waited >= budget) begin
         compared++;
         mismatched++;
         $display("FAIL %s_timeout: no done/error within %0d cycles", tag, budget);
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset();
      apply_reset();
      compared++;
      if ({bus.ps2_clk_low, bus.ps2_dat_low} !== 2'b00) begin
         mismatched++;
         $display("FAIL reset_lines: got %b%b, need 00", bus.ps2_clk_low, bus.ps2_dat_low);
      end
      compared++;
      if ({bus.busy, bus.done, bus.error} !== 3'b000) begin
         mismatched++;
         $display("FAIL reset_status: busy/done/error=%b%b%b, need 000",
                  bus.busy, bus.done, bus.error);
      end
      compared++;
      if (bus.err_code !== 2'b00) begin
         mismatched++;
         $display("FAIL reset_err_code: got %b, need 00", bus.err_code);
      end
   endtask

   // Full successful frame; returns at the cycle the done pulse is seen.
   task automatic full_frame(input logic [7:0] cmd, input logic [10:0] exp_bits,
                             input string tag, input bit poke);
      int         n_inh = 0;
      int         n_set = 0;
      int         rel;
      int         d0 = done_cnt;
      int         e0 = error_cnt;
      logic [10:0] bits;

      send_cmd(cmd);
      compared++;
      if (bus.busy !== 1'b1) begin
         mismatched++;
         $display("FAIL %s_busy_set: got %b, need 1", tag, bus.busy);
      end
      while (bus.ps2_clk_low === 1'b1 && bus.ps2_dat_low === 1'b0 && n_inh < 100) begin
         bus.send = poke && (n_inh == 3);
         if (bus.send) bus.cmd_byte = 8'h00;
         n_inh++;
         tick(1);
      end
      bus.send = 1'b0;
      while (bus.ps2_clk_low === 1'b1 && bus.ps2_dat_low === 1'b1 && n_set < 100) begin
         n_set++;
         tick(1);
      end
      compared++;
      if (n_inh != INH) begin
         mismatched++;
         $display("FAIL %s_inhibit_len: got %0d cycles, need %0d", tag, n_inh, INH);
      end
      compared++;
      if (n_set != SETUP) begin
         mismatched++;
         $display("FAIL %s_setup_len: got %0d cycles, need %0d", tag, n_set, SETUP);
      end

      wait_release(tag, rel);
      run_bfm(11, 1'b0, bits);
      compared++;
      if (bits !== exp_bits) begin
         mismatched++;
         $display("FAIL %s_frame_bits: got %b, need %b", tag, bits, exp_bits);
      end
      wait_count(tag, d0, e0, 40);
      compared++;
      if (done_cnt != d0 + 1 || error_cnt != e0) begin
         mismatched++;
         $display("FAIL %s_done: got %0d done / %0d error, need 1 / 0",
                  tag, done_cnt - d0, error_cnt - e0);
      end
      compared++;
      if (done_busy !== 1'b0 || bus.busy !== 1'b0) begin
         mismatched++;
         $display("FAIL %s_busy_clear: busy at done=%b now=%b, need 0/0",
                  tag, done_busy, bus.busy);
      end
      if (poke) begin
         tick(40);
         compared++;
         if (bus.busy !== 1'b0 || bus.ps2_clk_low !== 1'b0 || done_cnt != d0 + 1) begin
            mismatched++;
            $display("FAIL %s_single_frame: busy=%b clk_low=%b done=%0d, need 0/0/1",
                     tag, bus.busy, bus.ps2_clk_low, done_cnt - d0);
         end
      end
   endtask

   task automatic test_send_f4();
      full_frame(8'hF4, {1'b1, 1'b0, 8'hF4, 1'b0}, "f4", 1'b0);
   endtask

   task automatic test_send_ed();
      full_frame(8'hED, {1'b1, 1'b1, 8'hED, 1'b0}, "ed", 1'b0);
   endtask

   task automatic test_busy_ignore();
      full_frame(8'hF4, {1'b1, 1'b0, 8'hF4, 1'b0}, "ignore", 1'b1);
   endtask

   task automatic check_error(input string tag, input logic [1:0] code, input int e0);
      compared++;
      if (error_cnt != e0 + 1 || err_code_seen !== code || bus.err_code !== code) begin
         mismatched++;
         $display("FAIL %s_err_code: errors=%0d code@pulse=%b code now=%b, need 1/%b/%b",
                  tag, error_cnt - e0, err_code_seen, bus.err_code, code, code);
      end
      compared++;
      if ({err_clk_low, err_dat_low} !== 2'b00 || bus.busy !== 1'b0) begin
         mismatched++;
         $display("FAIL %s_release: lines@pulse=%b%b busy=%b, need 00/0",
                  tag, err_clk_low, err_dat_low, bus.busy);
      end
   endtask

   task automatic test_start_timeout();
      int rel;
      int d0 = done_cnt;
      int e0 = error_cnt;
      send_cmd(8'hFF);
      wait_release("start_to", rel);
      wait_count("start_to", d0, e0, 400);
      compared++;
      if (err_ncyc - rel != START) begin
         mismatched++;
         $display("FAIL start_to_latency: got %0d cycles, need %0d", err_ncyc - rel, START);
      end
      check_error("start_to", 2'b01, e0);
   endtask

   task automatic test_xfer_timeout();
      int         rel;
      int         d0 = done_cnt;
      int         e0 = error_cnt;
      logic [10:0] bits;
      send_cmd(8'hF4);
      wait_release("xfer_to", rel);
      run_bfm(5, 1'b0, bits);
      wait_count("xfer_to", d0, e0, 700);
      compared++;
      if (err_ncyc - rel != XFER) begin
         mismatched++;
         $display("FAIL xfer_to_latency: got %0d cycles, need %0d", err_ncyc - rel, XFER);
      end
      check_error("xfer_to", 2'b10, e0);
   endtask

   task automatic test_nack();
      int         rel;
      int         d0 = done_cnt;
      int         e0 = error_cnt;
      logic [10:0] bits;
      send_cmd(8'hF4);
      wait_release("nack", rel);
      run_bfm(11, 1'b1, bits);
      wait_count("nack", d0, e0, 40);
      tick(40);
      check_error("nack", 2'b11, e0);
      compared++;
      if (done_cnt != d0) begin
         mismatched++;
         $display("FAIL nack_no_done: got %0d done pulses, need 0", done_cnt - d0);
      end
   endtask

   task automatic test_reset_mid_shift();
      int         rel;
      int         d0 = done_cnt;
      int         e0 = error_cnt;
      logic [10:0] bits;
      send_cmd(8'hF4);
      wait_release("rst_mid", rel);
      run_bfm(4, 1'b0, bits);
      tick(2);
      // After the 4th fall the host drives D3 of 0xF4, which is 0.
      compared++;
      if ({bus.ps2_clk_low, bus.ps2_dat_low} !== 2'b01) begin
         mismatched++;
         $display("FAIL rst_mid_pre: lines=%b%b, need 01", bus.ps2_clk_low, bus.ps2_dat_low);
      end
      Resetn = 1'b0;
      #1;
      compared++;
      if ({bus.ps2_clk_low, bus.ps2_dat_low, bus.busy} !== 3'b000) begin
         mismatched++;
         $display("FAIL rst_mid_release: clk_low/dat_low/busy=%b%b%b, need 000",
                  bus.ps2_clk_low, bus.ps2_dat_low, bus.busy);
      end
      tick(3);
      Resetn = 1'b1;
      tick(20);
      compared++;
      if (done_cnt != d0 || error_cnt != e0) begin
         mismatched++;
         $display("FAIL rst_mid_pulses: got %0d done / %0d error, need 0 / 0",
                  done_cnt - d0, error_cnt - e0);
      end
   endtask

   task automatic test_back_to_back();
      full_frame(8'hED, {1'b1, 1'b1, 8'hED, 1'b0}, "b2b", 1'b0);
      send_cmd(8'hF4);
      compared++;
      if (bus.busy !== 1'b1 || bus.ps2_clk_low !== 1'b1 || bus.ps2_dat_low !== 1'b0) begin
         mismatched++;
         $display("FAIL b2b_accept: busy/clk_low/dat_low=%b%b%b, need 110",
                  bus.busy, bus.ps2_clk_low, bus.ps2_dat_low);
      end
      apply_reset();
   endtask

   initial begin
      bus.send     = 1'b0;
      bus.cmd_byte = 8'h00;
      test_reset();
      test_send_f4();
      test_send_ed();
      test_start_timeout();
      test_xfer_timeout();
      test_nack();
      test_reset_mid_shift();
      test_busy_ignore();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
